// File: rtl/ex_stage_v2_if.sv
// ID/EX inputs and EX/MEM registered outputs of the execute stage.
// master drives the stage (ID/EX side), slave is the stage itself.
interface ex_stage_v2_if;
  logic [1:0]  cALUSrcA, cALUSrcB;
  logic        cRegDst;
  logic [2:0]  cHiLoOp;
  logic [4:0]  cALUCtrl;
  logic        cBranch, cPCMux, cMemRead;
  logic [1:0]  cMemWrite;
  logic        cMove, cRegWriteCtrl, cRegAddress;
  logic [2:0]  cMemToReg;
  logic [1:0]  cSEMux;
  logic [31:0] PCPlus4, ReadReg1, ReadReg2, SEImm, Hi, Lo;
  logic [4:0]  I2016, I1511;

  logic        ocBranch, ocPCMux, ocMemRead;
  logic [1:0]  ocMemWrite;
  logic        ocMove, ocRegWriteCtrl, ocRegAddress;
  logic [2:0]  ocMemToReg;
  logic [1:0]  ocSEMux;
  logic        ocZero;
  logic [31:0] oPCPlus4, oReadReg1, oReadReg2, oHi, oLo, oPCSumImm, oALUResult;
  logic [63:0] oHiLoResult;
  logic [4:0]  oRegDstResult;

  modport master (
    output cALUSrcA, cALUSrcB, cRegDst, cHiLoOp, cALUCtrl, cBranch, cPCMux, cMemRead,
           cMemWrite, cMove, cRegWriteCtrl, cRegAddress, cMemToReg, cSEMux,
           PCPlus4, ReadReg1, ReadReg2, SEImm, Hi, Lo, I2016, I1511,
    input  ocBranch, ocPCMux, ocMemRead, ocMemWrite, ocMove, ocRegWriteCtrl, ocRegAddress,
           ocMemToReg, ocSEMux, ocZero, oPCPlus4, oReadReg1, oReadReg2, oHi, oLo,
           oPCSumImm, oALUResult, oHiLoResult, oRegDstResult
  );

  modport slave (
    input  cALUSrcA, cALUSrcB, cRegDst, cHiLoOp, cALUCtrl, cBranch, cPCMux, cMemRead,
           cMemWrite, cMove, cRegWriteCtrl, cRegAddress, cMemToReg, cSEMux,
           PCPlus4, ReadReg1, ReadReg2, SEImm, Hi, Lo, I2016, I1511,
    output ocBranch, ocPCMux, ocMemRead, ocMemWrite, ocMove, ocRegWriteCtrl, ocRegAddress,
           ocMemToReg, ocSEMux, ocZero, oPCPlus4, oReadReg1, oReadReg2, oHi, oLo,
           oPCSumImm, oALUResult, oHiLoResult, oRegDstResult
  );
endinterface

// File: rtl/ex_stage_v2.sv
// Execute stage: ALU, Hi/Lo multiply-accumulate, branch target and rd select,
// all captured into the EX/MEM register.
module ex_stage_v2 (
  input logic           Clk,
  input logic           Reset,
  ex_stage_v2_if.slave  bus
);
  logic [31:0] w_a, w_b, w_alu, w_pcsum;
  logic [4:0]  w_sh, w_rd;
  logic [63:0] w_hl, w_ps, w_pu, w_hlres;

  logic [12:0] r_ctrl;
  logic        r_zero;
  logic [31:0] r_pc4, r_rr1, r_rr2, r_hi, r_lo, r_pcsum, r_alu;
  logic [63:0] r_hilo;
  logic [4:0]  r_rd;

  always_comb begin
    w_a = bus.ReadReg1;
    case (bus.cALUSrcA)
      2'd0: w_a = bus.ReadReg1;
      2'd1: w_a = bus.ReadReg2;
      2'd2: w_a = bus.Hi;
      2'd3: w_a = bus.Lo;
    endcase
    w_b = bus.ReadReg2;
    case (bus.cALUSrcB)
      2'd0: w_b = bus.ReadReg2;
      2'd1: w_b = bus.SEImm;
      2'd2: w_b = {27'd0, bus.SEImm[10:6]};
      2'd3: w_b = {27'd0, bus.ReadReg1[4:0]};
    endcase
  end

  assign w_sh = w_b[4:0];

  always_comb begin
    w_alu = '0;
    case (bus.cALUCtrl)
      5'd0:  w_alu = w_a + w_b;
      5'd1:  w_alu = w_a - w_b;
      5'd2:  w_alu = w_a & w_b;
      5'd3:  w_alu = w_a | w_b;
      5'd4:  w_alu = w_a ^ w_b;
      5'd5:  w_alu = ~(w_a | w_b);
      5'd6:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      5'd7:  w_alu = {31'd0, w_a < w_b};
      5'd8:  w_alu = w_a << w_sh;
      5'd9:  w_alu = w_a >> w_sh;
      5'd10: w_alu = $signed(w_a) >>> w_sh;
      // a shift by 32 yields 0, so a rotate by 0 degenerates to w_a
      5'd11: w_alu = (w_a >> w_sh) | (w_a << (6'd32 - {1'b0, w_sh}));
      5'd12: w_alu = {w_b[15:0], 16'd0};
      5'd13: w_alu = w_a * w_b;
      5'd14: w_alu = w_a;
      5'd15: w_alu = w_b;
      5'd16: w_alu = {{24{w_a[7]}}, w_a[7:0]};
      5'd17: w_alu = {{16{w_a[15]}}, w_a[15:0]};
      default: w_alu = '0;
    endcase
  end

  // low 64 bits of the product of sign-extended operands equal the signed product
  assign w_hl = {bus.Hi, bus.Lo};
  assign w_ps = {{32{bus.ReadReg1[31]}}, bus.ReadReg1} * {{32{bus.ReadReg2[31]}}, bus.ReadReg2};
  assign w_pu = {32'd0, bus.ReadReg1} * {32'd0, bus.ReadReg2};

  always_comb begin
    w_hlres = w_hl;
    case (bus.cHiLoOp)
      3'd0: w_hlres = w_hl;
      3'd1: w_hlres = w_ps;
      3'd2: w_hlres = w_pu;
      3'd3: w_hlres = w_hl + w_ps;
      3'd4: w_hlres = w_hl + w_pu;
      3'd5: w_hlres = w_hl - w_ps;
      3'd6: w_hlres = w_hl - w_pu;
      3'd7: w_hlres = {bus.ReadReg1, bus.ReadReg1};
    endcase
  end

  assign w_pcsum = bus.PCPlus4 + {bus.SEImm[29:0], 2'b00};
  assign w_rd    = bus.cRegDst ? bus.I1511 : bus.I2016;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ctrl <= '0; r_zero <= 1'b0; r_pc4 <= '0; r_rr1 <= '0; r_rr2 <= '0;
      r_hi <= '0; r_lo <= '0; r_pcsum <= '0; r_alu <= '0; r_hilo <= '0; r_rd <= '0;
    end else begin
      r_ctrl  <= {bus.cBranch, bus.cPCMux, bus.cMemWrite, bus.cMemRead, bus.cMove,
                  bus.cRegWriteCtrl, bus.cMemToReg, bus.cSEMux, bus.cRegAddress};
      r_zero  <= (w_alu == 32'd0);
      r_pc4   <= bus.PCPlus4;
      r_rr1   <= bus.ReadReg1;
      r_rr2   <= bus.ReadReg2;
      r_hi    <= bus.Hi;
      r_lo    <= bus.Lo;
      r_pcsum <= w_pcsum;
      r_alu   <= w_alu;
      r_hilo  <= w_hlres;
      r_rd    <= w_rd;
    end
  end

  assign {bus.ocBranch, bus.ocPCMux, bus.ocMemWrite, bus.ocMemRead, bus.ocMove,
          bus.ocRegWriteCtrl, bus.ocMemToReg, bus.ocSEMux, bus.ocRegAddress} = r_ctrl;
  assign bus.ocZero        = r_zero;
  assign bus.oPCPlus4      = r_pc4;
  assign bus.oReadReg1     = r_rr1;
  assign bus.oReadReg2     = r_rr2;
  assign bus.oHi           = r_hi;
  assign bus.oLo           = r_lo;
  assign bus.oPCSumImm     = r_pcsum;
  assign bus.oALUResult    = r_alu;
  assign bus.oHiLoResult   = r_hilo;
  assign bus.oRegDstResult = r_rd;
endmodule

// File: tb/tb_ex_stage_v2.sv
// Directed + random bench for ex_stage_v2 with a scoreboard of expected EX/MEM values.
module tb_ex_stage_v2;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_v2_if bus ();
  ex_stage_v2 dut (.Clk(clk), .Reset(rst), .bus(bus.slave));

  typedef struct packed {
    logic [12:0] ctrl;
    logic        zero;
    logic [31:0] pc4, rr1, rr2, hi, lo, pcs, alu;
    logic [63:0] hilo;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] out_ctrl();
    return {bus.ocBranch, bus.ocPCMux, bus.ocMemWrite, bus.ocMemRead, bus.ocMove,
            bus.ocRegWriteCtrl, bus.ocMemToReg, bus.ocSEMux, bus.ocRegAddress};
  endfunction

  // Reference model computed from the stimulus driven this cycle
  function automatic exp_t model();
    exp_t e;
    logic [31:0] a, b, r;
    int unsigned s;
    longint sps;
    logic [63:0] pu, hl;
    e = '0;
    if (rst) return e;
    e.ctrl = {bus.cBranch, bus.cPCMux, bus.cMemWrite, bus.cMemRead, bus.cMove,
              bus.cRegWriteCtrl, bus.cMemToReg, bus.cSEMux, bus.cRegAddress};
    a = (bus.cALUSrcA == 0) ? bus.ReadReg1 : (bus.cALUSrcA == 1) ? bus.ReadReg2 :
        (bus.cALUSrcA == 2) ? bus.Hi : bus.Lo;
    b = (bus.cALUSrcB == 0) ? bus.ReadReg2 : (bus.cALUSrcB == 1) ? bus.SEImm :
        (bus.cALUSrcB == 2) ? ((bus.SEImm >> 6) & 32'h1F) : (bus.ReadReg1 & 32'h1F);
    s = b % 32;
    r = 0;
    case (bus.cALUCtrl)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~(a | b);
      6: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 1 : 0;
      7: r = (a < b) ? 1 : 0;
      8: r = a << s;
      9: r = a >> s;
      10: begin
        r = a >> s;
        if (a[31]) for (int i = 0; i < 32; i++) if (i >= 32 - int'(s)) r[i] = 1'b1;
      end
      11: begin r = a; repeat (s) r = {r[0], r[31:1]}; end
      12: r = b << 16;
      13: r = a * b;
      14: r = a;
      15: r = b;
      16: begin r = a & 32'hFF;   if (a[7])  r = r | 32'hFFFF_FF00; end
      17: begin r = a & 32'hFFFF; if (a[15]) r = r | 32'hFFFF_0000; end
      default: r = 0;
    endcase
    e.alu  = r;
    e.zero = (r == 0);
    sps = longint'($signed(bus.ReadReg1)) * longint'($signed(bus.ReadReg2));
    pu  = 64'(bus.ReadReg1) * 64'(bus.ReadReg2);
    hl  = {bus.Hi, bus.Lo};
    case (bus.cHiLoOp)
      0: e.hilo = hl;
      1: e.hilo = sps;
      2: e.hilo = pu;
      3: e.hilo = hl + sps;
      4: e.hilo = hl + pu;
      5: e.hilo = hl - sps;
      6: e.hilo = hl - pu;
      default: e.hilo = {bus.ReadReg1, bus.ReadReg1};
    endcase
    e.pc4 = bus.PCPlus4; e.rr1 = bus.ReadReg1; e.rr2 = bus.ReadReg2;
    e.hi  = bus.Hi;      e.lo  = bus.Lo;
    e.pcs = bus.PCPlus4 + bus.SEImm * 4;
    e.rd  = bus.cRegDst ? bus.I1511 : bus.I2016;
    return e;
  endfunction

  task automatic set_all(input logic [31:0] v);
    bus.cALUSrcA = v[1:0]; bus.cALUSrcB = v[1:0]; bus.cRegDst = v[0];
    bus.cHiLoOp = v[2:0]; bus.cALUCtrl = v[4:0]; bus.cBranch = v[0];
    bus.cPCMux = v[0]; bus.cMemRead = v[0]; bus.cMemWrite = v[1:0];
    bus.cMove = v[0]; bus.cRegWriteCtrl = v[0]; bus.cRegAddress = v[0];
    bus.cMemToReg = v[2:0]; bus.cSEMux = v[1:0];
    bus.PCPlus4 = v; bus.ReadReg1 = v; bus.ReadReg2 = v; bus.SEImm = v;
    bus.Hi = v; bus.Lo = v; bus.I2016 = v[4:0]; bus.I1511 = v[4:0];
  endtask

  task automatic rnd_in();
    bus.cALUSrcA = 2'($urandom); bus.cALUSrcB = 2'($urandom); bus.cRegDst = 1'($urandom);
    bus.cHiLoOp = 3'($urandom); bus.cALUCtrl = 5'($urandom); bus.cBranch = 1'($urandom);
    bus.cPCMux = 1'($urandom); bus.cMemRead = 1'($urandom); bus.cMemWrite = 2'($urandom);
    bus.cMove = 1'($urandom); bus.cRegWriteCtrl = 1'($urandom); bus.cRegAddress = 1'($urandom);
    bus.cMemToReg = 3'($urandom); bus.cSEMux = 2'($urandom);
    bus.PCPlus4 = $urandom; bus.ReadReg1 = $urandom; bus.ReadReg2 = $urandom;
    bus.SEImm = $urandom; bus.Hi = $urandom; bus.Lo = $urandom;
    bus.I2016 = 5'($urandom); bus.I1511 = 5'($urandom);
  endtask

  // Push expectation for the current inputs, clock once, pop and compare
  task automatic step();
    exp_t e;
    sb.push_back(model());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    last = e;
    cmp("ctrl",  out_ctrl(),         e.ctrl);
    cmp("zero",  bus.ocZero,         e.zero);
    cmp("pc4",   bus.oPCPlus4,       e.pc4);
    cmp("rr1",   bus.oReadReg1,      e.rr1);
    cmp("rr2",   bus.oReadReg2,      e.rr2);
    cmp("hi",    bus.oHi,            e.hi);
    cmp("lo",    bus.oLo,            e.lo);
    cmp("pcsum", bus.oPCSumImm,      e.pcs);
    cmp("alu",   bus.oALUResult,     e.alu);
    cmp("hilo",  bus.oHiLoResult,    e.hilo);
    cmp("rd",    bus.oRegDstResult,  e.rd);
  endtask

  initial begin
    // reset with every input nonzero
    rst = 1'b1;
    set_all(32'hFFFF_FFFF);
    @(negedge clk);
    step();
    cmp("rst_hilo", bus.oHiLoResult, 64'd0);
    cmp("rst_zero", bus.ocZero, 1'b0);
    cmp("rst_ctrl", out_ctrl(), 13'd0);

    // shift by shamt 0 and pass-throughs
    rst = 1'b0;
    set_all(32'd0);
    bus.cALUCtrl = 5'd9; bus.cALUSrcA = 2'd1; bus.cALUSrcB = 2'd2;
    bus.ReadReg2 = 32'd40; bus.SEImm = 32'd20; bus.cHiLoOp = 3'd1;
    bus.Hi = 32'd1; bus.Lo = 32'd2;
    step();
    cmp("shift_alu", bus.oALUResult, 32'd40);
    cmp("shift_zero", bus.ocZero, 1'b0);
    cmp("shift_hilo", bus.oHiLoResult, 64'd0);
    cmp("shift_hi", bus.oHi, 32'd1);
    cmp("shift_lo", bus.oLo, 32'd2);
    cmp("shift_pcs", bus.oPCSumImm, 32'd80);

    // signed add to zero
    set_all(32'd0);
    bus.ReadReg1 = 32'd5; bus.SEImm = 32'hFFFF_FFFB; bus.cALUSrcB = 2'd1;
    step();
    cmp("add_alu", bus.oALUResult, 32'd0);
    cmp("add_zero", bus.ocZero, 1'b1);

    // SLT / SLTU
    set_all(32'd0);
    bus.ReadReg1 = 32'hFFFF_FFFF; bus.ReadReg2 = 32'd1; bus.cALUCtrl = 5'd6;
    step();
    cmp("slt", bus.oALUResult, 32'd1);
    bus.cALUCtrl = 5'd7;
    step();
    cmp("sltu", bus.oALUResult, 32'd0);
    cmp("sltu_zero", bus.ocZero, 1'b1);

    // latency: mid-cycle input change must not reach the outputs
    bus.cALUCtrl = 5'd0; bus.ReadReg1 = 32'd77; bus.cHiLoOp = 3'd7;
    #2;
    cmp("hold_alu", bus.oALUResult, last.alu);
    cmp("hold_hilo", bus.oHiLoResult, last.hilo);
    step();
    cmp("lat_alu", bus.oALUResult, 32'd78);

    // Hi/Lo multiplies
    set_all(32'd0);
    bus.ReadReg1 = 32'hFFFF_FFFF; bus.ReadReg2 = 32'd2; bus.cHiLoOp = 3'd1;
    step();
    cmp("mult", bus.oHiLoResult, 64'hFFFF_FFFF_FFFF_FFFE);
    bus.cHiLoOp = 3'd2;
    step();
    cmp("multu", bus.oHiLoResult, 64'h0000_0001_FFFF_FFFE);
    bus.cHiLoOp = 3'd3; bus.Hi = 32'd0; bus.Lo = 32'd3;
    step();
    cmp("madd", bus.oHiLoResult, 64'd1);

    // rotate-right by the variable shift amount in rs[4:0]
    set_all(32'd0);
    bus.cALUCtrl = 5'd11; bus.cALUSrcA = 2'd1; bus.cALUSrcB = 2'd3;
    bus.ReadReg2 = 32'h8000_0001; bus.ReadReg1 = 32'd1;
    step();
    cmp("rotr", bus.oALUResult, 32'hC000_0000);

    // controls and destination register
    set_all(32'd1);
    bus.I1511 = 5'd31; bus.I2016 = 5'd7;
    step();
    cmp("ctrl_ones", out_ctrl(), 13'b1_1_01_1_1_1_001_01_1);
    cmp("rd_rd", bus.oRegDstResult, 5'd31);
    bus.cRegDst = 1'b0;
    step();
    cmp("rd_rt", bus.oRegDstResult, 5'd7);

    // mid-stream reset drops the in-flight instruction, then capture resumes
    rnd_in();
    rst = 1'b1;
    step();
    cmp("midrst_alu", bus.oALUResult, 32'd0);
    rst = 1'b0;
    step();

    // random sweep over all operations and controls
    for (int n = 0; n < 60; n++) begin
      rnd_in();
      rst = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage_v2.md
# ex_stage_v2

Execute stage of the 5-stage MIPS-style pipeline, including the EX/MEM pipeline register. It computes the ALU result and zero flag, the 64-bit Hi/Lo multiply/accumulate result, the branch target and the destination register number. Every result and the forwarded MEM/WB control bits are registered into the MEM stage on the rising clock edge.

## Interface
- Parameters: none.
- Clk  in  1  pipeline clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high; clears every output register to 0.
- cALUSrcA  in  2  ALU A-operand select.
- cALUSrcB  in  2  ALU B-operand select.
- cRegDst  in  1  destination register select.
- cHiLoOp  in  3  Hi/Lo unit operation.
- cALUCtrl  in  5  ALU operation.
- cBranch, cPCMux, cMemRead  in  1 each  MEM-stage controls, passed through.
- cMemWrite  in  2  MEM-stage control, passed through.
- cMove, cRegWriteCtrl, cRegAddress  in  1 each  WB-stage controls, passed through.
- cMemToReg  in  3  WB-stage control, passed through.
- cSEMux  in  2  WB-stage control, passed through.
- PCPlus4, ReadReg1, ReadReg2, SEImm, Hi, Lo  in  32 each  ID/EX data.
- I2016, I1511  in  5 each  instruction fields rt and rd.
- ocBranch, ocPCMux, ocMemWrite, ocMemRead, ocMove, ocRegWriteCtrl, ocMemToReg, ocSEMux, ocRegAddress  out  same width as input  registered copies of the c* controls.
- ocZero  out  1  registered flag, set when the ALU result is 0.
- oPCPlus4, oReadReg1, oReadReg2, oHi, oLo  out  32 each  registered copies of the inputs.
- oPCSumImm  out  32  registered branch target.
- oALUResult  out  32  registered ALU result.
- oHiLoResult  out  64  registered {Hi,Lo} result; bits [63:32] are the new Hi.
- oRegDstResult  out  5  registered destination register number.

## Operation
- A operand mux (cALUSrcA): 0 ReadReg1, 1 ReadReg2, 2 Hi, 3 Lo.
- B operand mux (cALUSrcB): 0 ReadReg2, 1 SEImm, 2 SEImm[10:6] zero-extended (shamt), 3 ReadReg1[4:0] zero-extended (variable shift amount).
- ALU operations (cALUCtrl):
  - 0 ADD A+B; 1 SUB A−B; 2 AND; 3 OR; 4 XOR; 5 NOR.
  - 6 SLT signed, gives 1/0; 7 SLTU unsigned, gives 1/0.
  - 8 SLL A<<B[4:0]; 9 SRL A>>B[4:0]; 10 SRA arithmetic; 11 ROTR A rotate-right B[4:0].
  - 12 LUI B<<16; 13 MUL, low 32 bits of the signed A×B.
  - 14 pass A; 15 pass B.
  - 16 SEB, sign-extend A[7:0]; 17 SEH, sign-extend A[15:0].
  - 18–31 give 0.
- Add and subtract wrap modulo 2^32. No overflow trap is raised.
- Zero flag = (ALU result == 0).
- Hi/Lo unit uses ReadReg1 (rs) and ReadReg2 (rt), not the muxed operands. Operations (cHiLoOp):
  - 0 pass {Hi,Lo}; 1 MULT signed rs×rt; 2 MULTU unsigned rs×rt.
  - 3 MADD {Hi,Lo}+signed product; 4 MADDU {Hi,Lo}+unsigned product.
  - 5 MSUB {Hi,Lo}−signed product; 6 MSUBU {Hi,Lo}−unsigned product.
  - 7 {rs,rs}, which serves MTHI/MTLO; WB selects the half.
- All 64-bit arithmetic wraps modulo 2^64.
- oPCSumImm = PCPlus4 + (SEImm<<2), modulo 2^32.
- oRegDstResult = cRegDst ? I1511 : I2016.
- The stage has no stall and no flush input. A bubble is injected upstream by zeroing the controls.

## Timing
- All logic ahead of the output register is purely combinational.
- Latency is exactly 1 cycle: outputs reflect the inputs present at the prior rising edge of Clk.
- On a rising edge with Reset=1, every output becomes 0 regardless of the inputs. Reset wins over simultaneous input changes.
- A mid-stream reset discards the in-flight instruction. Normal capture resumes on the first edge with Reset=0.
- Outputs hold their value between edges. Input changes between edges have no effect on the outputs.

## Test plan
- Reset: Reset=1 with all inputs nonzero → after the edge every output is 0, including oHiLoResult and ocZero.
- Shift / pass-through: cALUCtrl=9, cALUSrcA=1, cALUSrcB=2, ReadReg2=40, SEImm=20, ReadReg1=0, cHiLoOp=1, Hi=1, Lo=2, PCPlus4=0 → next edge:
  - oALUResult=40 (shamt 0), ocZero=0.
  - oHiLoResult=0, since 0×40.
  - oHi=1, oLo=2, oPCSumImm=80.
- Signed arithmetic: ReadReg1=5, SEImm=0xFFFFFFFB, cALUSrcB=1 with ADD → oALUResult=0, ocZero=1. With SLT, ReadReg1=−1 and ReadReg2=1 → 1; SLTU gives 0.
- Hi/Lo: ReadReg1=0xFFFFFFFF, ReadReg2=2:
  - MULT → 0xFFFFFFFF_FFFFFFFE; MULTU → 0x00000001_FFFFFFFE.
  - MADD with Hi=0, Lo=3 → 1.
- Control and register destination: all c* inputs set to 1 → the matching oc* outputs equal 1 after one edge. cRegDst=1 with I1511=31, I2016=7 → oRegDstResult=31; cRegDst=0 → 7.
- Latency: change inputs mid-cycle → outputs change only at the next rising edge.
